// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkt_pkg
// Brief   : Shared types and constants for the UART packet framer.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkt_pkg;

  // Frame fields in transmit order
  typedef enum logic [2:0] {
    F_SYNC = 3'd0,
    F_DEST = 3'd1,
    F_SRC  = 3'd2,
    F_LEN  = 3'd3,
    F_DATA = 3'd4,
    F_CSUM = 3'd5
  } field_e;

  // Framer sequencing states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'h55;

  // Running checksum step; the carry out is discarded so the sum wraps mod 256
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_payload_buf.sv
`default_nettype none
// ============================================================================
// Module  : pkt_payload_buf
// Brief   : Payload byte store: appends at the write pointer (which doubles
//           as the fill count) and reads any slot by index.
// Revision: 1.0 - initial release
// ============================================================================
module pkt_payload_buf #(
  parameter int DEPTH = 16,
  parameter int CW    = 5,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clear,
  input  logic [AW-1:0] rd_idx,
  output logic [CW-1:0] count,
  output logic          full,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next fill level and storage contents; clearing only rewinds the count
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wr_en) begin
      mem_d[count_q[AW-1:0]] = wr_data;
      count_d                = count_q + CW'(1);
    end
  end

  // Count is reset; data slots need no reset since count gates their use
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/uart_packet_framer.sv
`default_nettype none
// ============================================================================
// Module  : uart_packet_framer
// Brief   : Buffers a payload and sends it to a UART transmitter as
//           SYNC, Dest, Source, Length, Data..., [Checksum], one byte per
//           UART send/busy handshake.
// Revision: 1.0 - initial release
// ============================================================================
module uart_packet_framer
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter logic [7:0] SOURCE_ADDR = 8'hAA,
  parameter bit         CHECKSUM_EN = 1'b1,
  localparam int        CW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          ipClk,
  input  logic          ipReset,
  input  logic [7:0]    ipDest,
  input  logic          ipStart,
  input  logic [7:0]    ipWrData,
  input  logic          ipWrValid,
  output logic          opWrReady,
  output logic [CW-1:0] opCount,
  output logic [7:0]    opTxData,
  output logic          opTxSend,
  input  logic          ipTxBusy,
  output logic          opBusy,
  output logic          opDone
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  state_e        state_q, state_d;
  field_e        field_q, field_d;
  logic [7:0]    dest_q, dest_d;
  logic [CW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          w_wr_en;
  logic          w_start;
  logic          w_clear;
  logic          w_buf_full;
  logic [CW-1:0] w_buf_count;
  logic [AW-1:0] w_rd_idx;
  logic [7:0]    w_rd_data;
  logic          w_last_data;
  logic          w_more;
  field_e        w_next_field;
  logic [7:0]    w_next_byte;

  assign opWrReady = (state_q == S_IDLE) && !w_buf_full;
  assign w_wr_en   = ipWrValid && opWrReady;
  assign w_start   = (state_q == S_IDLE) && ipStart && !ipTxBusy;

  // The buffer index of the next data byte is known one field ahead, so the
  // read data is settled by the time the WAIT state advances into it
  assign w_rd_idx    = (field_q == F_DATA) ? (idx_q + AW'(1)) : '0;
  assign w_last_data = ((CW'(idx_q) + CW'(1)) == len_q);

  pkt_payload_buf #(
    .DEPTH (MAX_PAYLOAD),
    .CW    (CW),
    .AW    (AW)
  ) u_buf (
    .clk     (ipClk),
    .rst_n   (ipReset),
    .wr_en   (w_wr_en),
    .wr_data (ipWrData),
    .clear   (w_clear),
    .rd_idx  (w_rd_idx),
    .count   (w_buf_count),
    .full    (w_buf_full),
    .rd_data (w_rd_data)
  );

  // Pick the field that follows the current one once the UART goes idle
  always_comb begin
    w_more       = 1'b1;
    w_next_field = field_q;
    case (field_q)
      F_SYNC: w_next_field = F_DEST;
      F_DEST: w_next_field = F_SRC;
      F_SRC:  w_next_field = F_LEN;
      F_LEN: begin
        if (len_q != '0)      w_next_field = F_DATA;
        else if (CHECKSUM_EN) w_next_field = F_CSUM;
        else                  w_more       = 1'b0;
      end
      F_DATA: begin
        if (!w_last_data)     w_next_field = F_DATA;
        else if (CHECKSUM_EN) w_next_field = F_CSUM;
        else                  w_more       = 1'b0;
      end
      default: w_more = 1'b0;
    endcase

    case (w_next_field)
      F_SYNC:  w_next_byte = SYNC_BYTE;
      F_DEST:  w_next_byte = dest_q;
      F_SRC:   w_next_byte = SOURCE_ADDR;
      F_LEN:   w_next_byte = 8'(len_q);
      F_DATA:  w_next_byte = w_rd_data;
      default: w_next_byte = csum_q;
    endcase
  end

  // Framer next-state logic: each field is one SEND/WAIT handshake
  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    dest_d    = dest_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    w_clear   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d   = S_SEND;
          field_d   = F_SYNC;
          idx_d     = '0;
          dest_d    = ipDest;
          // A write landing in the start cycle is part of this frame
          len_d     = w_buf_count + CW'(w_wr_en);
          csum_d    = 8'h00;
          tx_data_d = SYNC_BYTE;
        end
      end
      S_SEND: begin
        if (ipTxBusy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!ipTxBusy) begin
          if (w_more) begin
            state_d   = S_SEND;
            field_d   = w_next_field;
            tx_data_d = w_next_byte;
            if (w_next_field == F_DATA) idx_d = w_rd_idx;
            if (w_next_field != F_CSUM) csum_d = csum_add(csum_q, w_next_byte);
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        w_clear = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state_q   <= S_IDLE;
      field_q   <= F_SYNC;
      dest_q    <= 8'h00;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= 8'h00;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      dest_q    <= dest_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign opCount  = w_buf_count;
  assign opTxData = tx_data_q;
  assign opTxSend = (state_q == S_SEND);
  assign opBusy   = (state_q != S_IDLE);
  assign opDone   = (state_q == S_FINISH);

endmodule
`default_nettype wire
